soc_evt_serializer: RTL and testbench
=====================================

SOC_EVT_SERIALIZER -- requirements
Module: soc_evt_serializer

Interface
REQ-001 SHALL have parameter NUM_SRC, default 32: number of event sources, range 2..64.
REQ-002 SHALL have parameter EVT_ID_WIDTH, default 8: width of emitted event ID.
REQ-003 SHALL have parameter ID_BASE, default 0: ID emitted for source 0; ID_BASE+NUM_SRC-1 SHALL fit in EVT_ID_WIDTH bits, checked at elaboration.
REQ-004 clk_i  input  1  clock; all state updates on rising edge.
REQ-005 rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 evt_i  input  NUM_SRC  single-cycle event pulses, one bit per source, already synchronous to clk_i.
REQ-007 evt_valid_o  output  1  event ID available; drives the interrupt controller's event FIFO valid input.
REQ-008 evt_ready_i  input  1  downstream accepts; driven by the event FIFO not-full (grant) output.
REQ-009 evt_id_o  output  EVT_ID_WIDTH  event ID, ID_BASE + source index.
REQ-010 pending_o  output  NUM_SRC  current pending bit per source.
REQ-011 err_o  output  1  sticky overflow flag.
REQ-012 err_src_o  output  6  index of the first source that overflowed since the last clear.
REQ-013 clr_err_i  input  1  single-cycle clear of err_o and err_src_o.

Function
REQ-014 Pulse on evt_i[i] SHALL set pending[i] at the next edge.
REQ-015 Output stage SHALL be one register (valid + ID); it is "free" when evt_valid_o=0 or evt_valid_o&evt_ready_i.
REQ-016 When free and any pending bit is set, the block SHALL select one source by round-robin, load its ID into the output register and clear its pending bit, all at the same edge.
REQ-017 Round-robin search SHALL start at last-granted index +1, wrap from NUM_SRC-1 to 0; pointer after reset SHALL make source 0 highest priority.
REQ-018 Latency from idle: evt_i[i] high in cycle 0 -> pending_o[i] in cycle 1 -> evt_valid_o=1 with evt_id_o=ID_BASE+i in cycle 2.
REQ-019 With evt_ready_i held high and sources pending, throughput SHALL be one ID per cycle with no bubbles.
REQ-020 While evt_valid_o=1 and evt_ready_i=0, evt_valid_o and evt_id_o SHALL remain stable.
REQ-021 evt_i[i] in the same cycle as source i is granted SHALL leave pending[i]=1 and SHALL NOT be an overflow.
REQ-022 evt_i[i] while pending[i]=1 and source i not granted that cycle SHALL be an overflow: event dropped, err_o set next edge.
REQ-023 err_src_o SHALL capture the lowest-index overflowing source only when err_o was 0; later overflows SHALL NOT change it.
REQ-024 clr_err_i SHALL clear err_o and err_src_o at the next edge; an overflow in the same cycle SHALL win (err_o=1, err_src_o = that source).
REQ-025 Events simultaneous on several sources SHALL all be recorded as pending; none lost.
REQ-026 evt_valid_o SHALL never deassert without a handshake.

Reset
REQ-027 On rst_ni low, pending, err_o, err_src_o, evt_valid_o and evt_id_o SHALL go to 0 and the round-robin pointer to NUM_SRC-1, asynchronously.
REQ-028 Reset mid-operation SHALL discard pending events and any un-handshaken output without an overflow indication.
REQ-029 First grant SHALL be possible at the first clock edge after reset release.

Structure
REQ-030 Package soc_evt_pkg SHALL hold the default NUM_SRC, EVT_ID_WIDTH, ID_BASE constants and the err_src width constant.
REQ-031 Round-robin selection SHALL be a sub-module rr_idx_arbiter (request vector + pointer in -> grant valid + index out, purely combinational).
REQ-032 No FIFO SHALL be instantiated; buffering is one pending bit per source plus the output register.

Verification
REQ-033 Idle, ready=1; pulse evt_i[5] cycle 0 -> evt_valid_o=1, evt_id_o=5 in cycle 2 only; pending_o=0 by cycle 3.
REQ-034 ready=1; pulse evt_i[0],[3],[31] same cycle -> IDs 0,3,31 on three consecutive cycles; then pulse [0],[3] -> IDs 0,3 (no starvation after wrap).
REQ-035 ready=0; pulse evt_i[2] -> ID 2 held for 10 cycles; raise ready -> one handshake, evt_valid_o=0 next cycle.
REQ-036 ready=0 with ID 7 held; pulse evt_i[7] twice more -> pending_o[7]=1, err_o=1, err_src_o=7; pulse clr_err_i -> err_o=0.
REQ-037 ID_BASE=32, NUM_SRC=16; pulse evt_i[15] -> evt_id_o=47.
REQ-038 Assert rst_ni low with pending=0x0000_00F0 and evt_valid_o=1 -> all outputs 0 immediately; after release, pulse evt_i[1] -> ID 1 first.

Source files
------------

// File: rtl/soc_evt_pkg.sv
// Shared constants for the event serializer: default geometry and the error-index width.
package soc_evt_pkg;

   localparam int NUM_SRC_DEF      = 32;
   localparam int EVT_ID_WIDTH_DEF = 8;
   localparam int ID_BASE_DEF      = 0;
   // Wide enough to name any of up to 64 sources.
   localparam int ERR_SRC_W        = 6;

endpackage

// File: rtl/rr_idx_arbiter.sv
// Combinational round-robin picker: scans the request vector starting one past the pointer,
// wrapping at N-1, and reports the first hit as an index.
module rr_idx_arbiter #(
   parameter int N     = 32,
   parameter int IDX_W = 6
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic             gnt_valid_o,
   output logic [IDX_W-1:0] gnt_idx_o
);

   int            cand;
   logic [N-1:0]  req_sh;

   // Walk offsets from farthest to nearest so the nearest requester is the last one written.
   always_comb begin
      gnt_valid_o = 1'b0;
      gnt_idx_o   = '0;
      cand        = 0;
      req_sh      = '0;
      for (int off = N; off >= 1; off--) begin
         cand   = (int'(ptr_i) + off) % N;
         req_sh = req_i >> cand;
         if (req_sh[0]) begin
            gnt_valid_o = 1'b1;
            gnt_idx_o   = IDX_W'(cand);
         end
      end
   end

endmodule

// File: rtl/soc_evt_serializer.sv
// Collects single-cycle event pulses into per-source pending bits and emits them one ID at a
// time through a single valid/ready output register, with sticky overflow reporting.
module soc_evt_serializer
   import soc_evt_pkg::*;
#(
   parameter int NUM_SRC      = NUM_SRC_DEF,
   parameter int EVT_ID_WIDTH = EVT_ID_WIDTH_DEF,
   parameter int ID_BASE      = ID_BASE_DEF
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NUM_SRC-1:0]      evt_i,
   output logic                    evt_valid_o,
   input  logic                    evt_ready_i,
   output logic [EVT_ID_WIDTH-1:0] evt_id_o,
   output logic [NUM_SRC-1:0]      pending_o,
   output logic                    err_o,
   output logic [ERR_SRC_W-1:0]    err_src_o,
   input  logic                    clr_err_i
);

   if (NUM_SRC < 2 || NUM_SRC > 64) begin : g_bad_num_src
      $error("soc_evt_serializer: NUM_SRC must be in 2..64");
   end
   if (((ID_BASE + NUM_SRC - 1) >> EVT_ID_WIDTH) != 0) begin : g_bad_id_range
      $error("soc_evt_serializer: ID_BASE+NUM_SRC-1 does not fit in EVT_ID_WIDTH");
   end

   // Handshake: an ID transfers on any edge where evt_valid_o and evt_ready_i are both high;
   // once raised, evt_valid_o and evt_id_o hold until that transfer happens.
   logic [NUM_SRC-1:0]   pending_q;
   logic [NUM_SRC-1:0]   gnt_mask;
   logic [NUM_SRC-1:0]   ovf;
   logic [ERR_SRC_W-1:0] rr_ptr_q;
   logic [ERR_SRC_W-1:0] gnt_idx;
   logic [ERR_SRC_W-1:0] ovf_idx;
   logic                 gnt_valid;
   logic                 out_free;
   logic                 grant;

   rr_idx_arbiter #(
      .N     (NUM_SRC),
      .IDX_W (ERR_SRC_W)
   ) u_arb (
      .req_i       (pending_q),
      .ptr_i       (rr_ptr_q),
      .gnt_valid_o (gnt_valid),
      .gnt_idx_o   (gnt_idx)
   );

   assign out_free = !evt_valid_o || evt_ready_i;
   assign grant    = out_free && gnt_valid;
   assign gnt_mask = grant ? (NUM_SRC'(1) << gnt_idx) : '0;
   // A pulse on the source being granted this edge re-arms it rather than overflowing.
   assign ovf      = evt_i & pending_q & ~gnt_mask;

   always_comb begin
      ovf_idx = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (ovf[i]) ovf_idx = ERR_SRC_W'(i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pending_q   <= '0;
         rr_ptr_q    <= ERR_SRC_W'(NUM_SRC - 1);
         evt_valid_o <= 1'b0;
         evt_id_o    <= '0;
      end else begin
         pending_q <= (pending_q & ~gnt_mask) | evt_i;
         if (grant) begin
            evt_valid_o <= 1'b1;
            evt_id_o    <= EVT_ID_WIDTH'(ID_BASE) + EVT_ID_WIDTH'(gnt_idx);
            rr_ptr_q    <= gnt_idx;
         end else if (evt_valid_o && evt_ready_i) begin
            evt_valid_o <= 1'b0;
         end
      end
   end

   // A fresh overflow beats a simultaneous clear; the first offender is kept until cleared.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_o     <= 1'b0;
         err_src_o <= '0;
      end else if ((|ovf) && (!err_o || clr_err_i)) begin
         err_o     <= 1'b1;
         err_src_o <= ovf_idx;
      end else if (clr_err_i) begin
         err_o     <= 1'b0;
         err_src_o <= '0;
      end
   end

   assign pending_o = pending_q;

endmodule

// File: tb/tb_soc_evt_serializer.sv
// Directed self-checking bench for soc_evt_serializer: default instance plus a 16-source,
// base-32 instance for ID offset checking.
module tb_soc_evt_serializer;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;

   logic [31:0] evt_i = '0;
   logic        evt_ready_i = 1'b1;
   logic        clr_err_i = 1'b0;
   logic        evt_valid_o;
   logic [7:0]  evt_id_o;
   logic [31:0] pending_o;
   logic        err_o;
   logic [5:0]  err_src_o;

   logic [15:0] evt16_i = '0;
   logic        ready16_i = 1'b1;
   logic        clr16_i = 1'b0;
   logic        valid16_o;
   logic [7:0]  id16_o;
   logic [15:0] pending16_o;
   logic        err16_o;
   logic [5:0]  err_src16_o;

   int n_checks = 0;
   int n_fail   = 0;

   soc_evt_serializer u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .evt_i       (evt_i),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_id_o    (evt_id_o),
      .pending_o   (pending_o),
      .err_o       (err_o),
      .err_src_o   (err_src_o),
      .clr_err_i   (clr_err_i)
   );

   soc_evt_serializer #(
      .NUM_SRC      (16),
      .EVT_ID_WIDTH (8),
      .ID_BASE      (32)
   ) u_dut16 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .evt_i       (evt16_i),
      .evt_valid_o (valid16_o),
      .evt_ready_i (ready16_i),
      .evt_id_o    (id16_o),
      .pending_o   (pending16_o),
      .err_o       (err16_o),
      .err_src_o   (err_src16_o),
      .clr_err_i   (clr16_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   // Inputs change and outputs are sampled 1 time unit after each rising edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic pulse(input logic [31:0] v);
      evt_i = v;
      step();
      evt_i = '0;
   endtask

   task automatic apply_reset();
      evt_i = '0; evt16_i = '0; clr_err_i = 1'b0; clr16_i = 1'b0;
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
   endtask

   task automatic chk_out(input string name, input logic v_exp, input logic [7:0] id_exp);
      n_checks++;
      if (evt_valid_o !== v_exp || (v_exp && evt_id_o !== id_exp)) begin
         n_fail++;
         $display("FAIL %s: valid=%b id=%0d, expected valid=%b id=%0d",
                  name, evt_valid_o, evt_id_o, v_exp, id_exp);
      end
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      #3;
      n_checks++;
      if ({evt_valid_o, evt_id_o, pending_o, err_o, err_src_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: valid=%b id=%0d pend=%h err=%b src=%0d, expected all 0",
                  evt_valid_o, evt_id_o, pending_o, err_o, err_src_o);
      end
      step();
      rst_ni = 1'b1;
   endtask

   task automatic test_latency();
      apply_reset();
      evt_ready_i = 1'b1;
      pulse(32'h20);
      n_checks++;
      if (pending_o !== 32'h20 || evt_valid_o !== 1'b0) begin
         n_fail++;
         $display("FAIL lat_cycle1: pend=%h valid=%b, expected pend=00000020 valid=0", pending_o, evt_valid_o);
      end
      step();
      chk_out("lat_cycle2", 1'b1, 8'd5);
      n_checks++;
      if (pending_o !== 32'h0) begin
         n_fail++;
         $display("FAIL lat_pend_clr: pend=%h, expected 0", pending_o);
      end
      step();
      chk_out("lat_cycle3", 1'b0, 8'd0);
   endtask

   task automatic test_round_robin();
      apply_reset();
      evt_ready_i = 1'b1;
      pulse(32'h8000_0009);
      n_checks++;
      if (pending_o !== 32'h8000_0009) begin
         n_fail++;
         $display("FAIL rr_pending: pend=%h, expected 80000009", pending_o);
      end
      step(); chk_out("rr_first_0", 1'b1, 8'd0);
      step(); chk_out("rr_second_3", 1'b1, 8'd3);
      step(); chk_out("rr_third_31", 1'b1, 8'd31);
      pulse(32'h9);
      chk_out("rr_bubble", 1'b0, 8'd0);
      step(); chk_out("rr_wrap_0", 1'b1, 8'd0);
      step(); chk_out("rr_wrap_3", 1'b1, 8'd3);
      step(); chk_out("rr_idle", 1'b0, 8'd0);
   endtask

   task automatic test_backpressure();
      apply_reset();
      evt_ready_i = 1'b0;
      pulse(32'h4);
      step();
      chk_out("bp_first", 1'b1, 8'd2);
      for (int i = 0; i < 10; i++) begin
         step();
         chk_out("bp_hold", 1'b1, 8'd2);
      end
      evt_ready_i = 1'b1;
      step();
      chk_out("bp_release", 1'b0, 8'd0);
   endtask

   task automatic chk_err(input string name, input logic e_exp, input logic [5:0] s_exp);
      n_checks++;
      if (err_o !== e_exp || err_src_o !== s_exp) begin
         n_fail++;
         $display("FAIL %s: err=%b src=%0d, expected err=%b src=%0d", name, err_o, err_src_o, e_exp, s_exp);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      evt_ready_i = 1'b0;
      pulse(32'h80);
      step();
      chk_out("ovf_held7", 1'b1, 8'd7);
      pulse(32'h80);
      chk_err("ovf_first_no_err", 1'b0, 6'd0);
      pulse(32'h80);
      n_checks++;
      if (pending_o !== 32'h80) begin
         n_fail++;
         $display("FAIL ovf_pending7: pend=%h, expected 00000080", pending_o);
      end
      chk_err("ovf_set7", 1'b1, 6'd7);
      pulse(32'h8);
      pulse(32'h8);
      chk_err("ovf_sticky_src", 1'b1, 6'd7);
      clr_err_i = 1'b1; step(); clr_err_i = 1'b0;
      chk_err("ovf_clear", 1'b0, 6'd0);
      clr_err_i = 1'b1; pulse(32'h80); clr_err_i = 1'b0;
      chk_err("ovf_clr_collide", 1'b1, 6'd7);
      clr_err_i = 1'b1; step(); clr_err_i = 1'b0;
      chk_err("ovf_clear2", 1'b0, 6'd0);
      chk_out("ovf_still_held", 1'b1, 8'd7);
      evt_ready_i = 1'b1;
      step(); chk_out("ovf_drain_3", 1'b1, 8'd3);
      step(); chk_out("ovf_drain_7", 1'b1, 8'd7);
      step(); chk_out("ovf_drain_idle", 1'b0, 8'd0);
   endtask

   task automatic test_reset_mid();
      apply_reset();
      evt_ready_i = 1'b0;
      pulse(32'h2);
      step();
      pulse(32'hF0);
      n_checks++;
      if (pending_o !== 32'hF0 || evt_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL rmid_setup: pend=%h valid=%b, expected pend=000000f0 valid=1", pending_o, evt_valid_o);
      end
      #2;
      rst_ni = 1'b0;
      #1;
      n_checks++;
      if ({evt_valid_o, evt_id_o, pending_o, err_o, err_src_o} !== '0) begin
         n_fail++;
         $display("FAIL rmid_async: valid=%b id=%0d pend=%h err=%b src=%0d, expected all 0",
                  evt_valid_o, evt_id_o, pending_o, err_o, err_src_o);
      end
      step();
      rst_ni = 1'b1;
      evt_ready_i = 1'b1;
      pulse(32'h2);
      step();
      chk_out("rmid_first_id1", 1'b1, 8'd1);
      chk_err("rmid_no_err", 1'b0, 6'd0);
   endtask

   task automatic test_id_base();
      apply_reset();
      ready16_i = 1'b1;
      evt16_i = 16'h8000;
      step();
      evt16_i = '0;
      step();
      n_checks++;
      if (valid16_o !== 1'b1 || id16_o !== 8'd47) begin
         n_fail++;
         $display("FAIL id_base_47: valid=%b id=%0d, expected valid=1 id=47", valid16_o, id16_o);
      end
      step();
      n_checks++;
      if (valid16_o !== 1'b0 || pending16_o !== 16'h0 || err16_o !== 1'b0) begin
         n_fail++;
         $display("FAIL id_base_idle: valid=%b pend=%h err=%b, expected 0", valid16_o, pending16_o, err16_o);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_round_robin();
      test_backpressure();
      test_overflow();
      test_reset_mid();
      test_id_base();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
